// File: rtl/road_fighter_pkg.sv
// Shared object-record types, field indices and scanner FSM states.
// Pure declarations; no logic, no latency, no flow control.
package road_fighter_pkg;

    typedef logic [0:4][0:10] obj_state_t;

    localparam int F_IMG    = 0;
    localparam int F_X      = 1;
    localparam int F_Y      = 2;
    localparam int F_W      = 3;
    localparam int F_H      = 4;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } scan_state_t;

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned bounding-box overlap test between two object records.
// Combinational, zero latency; no flow control.
module aabb_overlap
    import road_fighter_pkg::*;
(
    input  obj_state_t a,
    input  obj_state_t b,
    output logic       hit
);

    logic [11:0] w_ax, w_ay, w_aw, w_ah;
    logic [11:0] w_bx, w_by, w_bw, w_bh;
    logic        w_active;
    logic        w_nonzero;
    logic        w_x_ovl;
    logic        w_y_ovl;

    // Zero-extend to 12 bits so x+width never wraps.
    assign w_ax = {1'b0, a[F_X]};
    assign w_ay = {1'b0, a[F_Y]};
    assign w_aw = {1'b0, a[F_W]};
    assign w_ah = {1'b0, a[F_H]};
    assign w_bx = {1'b0, b[F_X]};
    assign w_by = {1'b0, b[F_Y]};
    assign w_bw = {1'b0, b[F_W]};
    assign w_bh = {1'b0, b[F_H]};

    assign w_active  = (a[F_IMG] != '0) && (b[F_IMG] != '0);
    // Strict compares alone would still let a zero-size box sit inside the other one.
    assign w_nonzero = (w_aw != '0) && (w_ah != '0) && (w_bw != '0) && (w_bh != '0);

    assign w_x_ovl = (w_ax < (w_bx + w_bw)) && (w_bx < (w_ax + w_aw));
    assign w_y_ovl = (w_ay < (w_by + w_bh)) && (w_by < (w_ay + w_ah));

    assign hit = w_active && w_nonzero && w_x_ovl && w_y_ovl;

endmodule

// File: rtl/car_collision_scanner.sv
// Snapshots player + NUM_AI car records on frame_start and tests one car per clock.
// scan_done NUM_AI+1 cycles after frame_start; no backpressure, a new frame_start restarts.
module car_collision_scanner
    import road_fighter_pkg::*;
#(
    parameter int NUM_AI = 3,
    parameter int IDX_W  = 3
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            frame_start,
    input  logic [0:4][0:10]                player_state,
    input  logic [0:NUM_AI-1][0:4][0:10]    ai_states,
    output logic                            busy,
    output logic                            scan_done,
    output logic                            collision,
    output logic [IDX_W-1:0]                collision_idx,
    output logic [NUM_AI-1:0]               collision_mask
);

    scan_state_t                     r_state;
    scan_state_t                     w_next_state;

    obj_state_t                      r_player;
    logic [0:NUM_AI-1][0:4][0:10]    r_ai;
    logic [NUM_AI-1:0]               r_work;
    logic [IDX_W-1:0]                r_idx;

    logic                            r_busy;
    logic                            r_scan_done;
    logic                            r_collision;
    logic [IDX_W-1:0]                r_collision_idx;
    logic [NUM_AI-1:0]               r_collision_mask;

    obj_state_t                      w_car;
    logic                            w_hit;
    logic                            w_last;
    logic [IDX_W-1:0]                w_lowest;

    assign w_last = (r_idx == IDX_W'(NUM_AI - 1));

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = IDLE;
            SCAN:    if (w_last) w_next_state = REPORT;
            REPORT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        // A new frame always wins: aborts a scan, or follows a REPORT directly.
        if (frame_start) begin
            w_next_state = SCAN;
        end
    end

    always_comb begin
        w_car = '0;
        for (int i = 0; i < NUM_AI; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_car = r_ai[i];
            end
        end
    end

    always_comb begin
        w_lowest = '0;
        for (int i = NUM_AI - 1; i >= 0; i--) begin
            if (r_work[i]) begin
                w_lowest = IDX_W'(i);
            end
        end
    end

    aabb_overlap u_aabb_overlap (
        .a   (r_player),
        .b   (w_car),
        .hit (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_player         <= '0;
            r_ai             <= '0;
            r_work           <= '0;
            r_idx            <= '0;
            r_busy           <= 1'b0;
            r_scan_done      <= 1'b0;
            r_collision      <= 1'b0;
            r_collision_idx  <= '0;
            r_collision_mask <= '0;
        end else begin
            r_scan_done <= 1'b0;
            r_collision <= 1'b0;

            if (r_state == SCAN) begin
                for (int i = 0; i < NUM_AI; i++) begin
                    if (r_idx == IDX_W'(i)) begin
                        r_work[i] <= w_hit;
                    end
                end
                if (!w_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end

            if (r_state == REPORT) begin
                r_scan_done      <= 1'b1;
                r_collision      <= |r_work;
                r_collision_mask <= r_work;
                r_collision_idx  <= w_lowest;
                r_busy           <= 1'b0;
            end

            // Placed last so a restart overrides the scan/report updates above.
            if (frame_start) begin
                r_player <= player_state;
                r_ai     <= ai_states;
                r_work   <= '0;
                r_idx    <= '0;
                r_busy   <= 1'b1;
            end
        end
    end

    assign busy           = r_busy;
    assign scan_done      = r_scan_done;
    assign collision      = r_collision;
    assign collision_idx  = r_collision_idx;
    assign collision_mask = r_collision_mask;

endmodule

// File: tb/tb_car_collision_scanner.sv
// Directed vector table plus hand-written restart/reset sequences for car_collision_scanner.
module tb_car_collision_scanner;
    import road_fighter_pkg::*;

    logic                       clk;
    logic                       resetN;
    logic                       frame_start;
    logic [0:4][0:10]           player_state;
    logic [0:2][0:4][0:10]      ai_states;
    logic                       busy;
    logic                       scan_done;
    logic                       collision;
    logic [2:0]                 collision_idx;
    logic [2:0]                 collision_mask;

    int n_tests = 0;
    int n_fail  = 0;

    car_collision_scanner #(.NUM_AI(3), .IDX_W(3)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .frame_start    (frame_start),
        .player_state   (player_state),
        .ai_states      (ai_states),
        .busy           (busy),
        .scan_done      (scan_done),
        .collision      (collision),
        .collision_idx  (collision_idx),
        .collision_mask (collision_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        obj_state_t p;
        obj_state_t c0;
        obj_state_t c1;
        obj_state_t c2;
        logic [2:0] mask;
        logic [2:0] idx;
    } vec_t;

    vec_t vecs[10];

    function automatic obj_state_t mk(input int img, input int x, input int y,
                                      input int w, input int h);
        obj_state_t o;
        o[F_IMG] = 11'(img);
        o[F_X]   = 11'(x);
        o[F_Y]   = 11'(y);
        o[F_W]   = 11'(w);
        o[F_H]   = 11'(h);
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        player_state = v.p;
        ai_states    = {v.c0, v.c1, v.c2};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string nm, input vec_t v, input logic exp_busy);
        chk({nm, " scan_done"}, 32'(scan_done), 32'd1);
        chk({nm, " collision"}, 32'(collision), 32'(|v.mask));
        chk({nm, " idx"},       32'(collision_idx), 32'(v.idx));
        chk({nm, " mask"},      32'(collision_mask), 32'(v.mask));
        chk({nm, " busy"},      32'(busy), 32'(exp_busy));
    endtask

    // Starts a frame with v; optionally swaps the inputs to alt right after the snapshot.
    task automatic run_frame(input vec_t v, input bit scramble, input vec_t alt);
        apply(v);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        if (scramble) apply(alt);
        chk({v.name, " busy start"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) chk({v.name, " early done"}, 32'(scan_done), 32'd0);
        end
        check_result(v.name, v, 1'b0);
        tick();
        chk({v.name, " done pulse"}, 32'(scan_done), 32'd0);
        chk({v.name, " mask held"}, 32'(collision_mask), 32'(v.mask));
    endtask

    obj_state_t pl, off;
    int pulses;

    initial begin
        pl  = mk(1, 256, 380, 32, 36);
        off = mk(0, 0, 0, 0, 0);
        vecs[0] = '{"hit car0",    pl, mk(1,270,400,32,36), off, off, 3'b001, 3'd0};
        vecs[1] = '{"touch x",     pl, off, mk(1,288,380,32,36), off, 3'b000, 3'd0};
        vecs[2] = '{"car0+car2",   pl, mk(1,270,400,32,36), off, mk(1,250,370,20,20), 3'b101, 3'd0};
        vecs[3] = '{"car2 only",   pl, off, off, mk(1,250,370,20,20), 3'b100, 3'd2};
        vecs[4] = '{"zero width",  pl, off, mk(1,260,390,0,10), off, 3'b000, 3'd0};
        vecs[5] = '{"player off",  mk(0,256,380,32,36), mk(1,256,380,32,36), off, off, 3'b000, 3'd0};
        vecs[6] = '{"touch y",     pl, off, mk(1,256,416,32,36), off, 3'b000, 3'd0};
        vecs[7] = '{"1px y",       pl, off, mk(1,256,415,32,36), off, 3'b010, 3'd1};
        vecs[8] = '{"all hit",     pl, pl, pl, pl, 3'b111, 3'd0};
        vecs[9] = '{"big coords",  mk(1,2000,2000,47,47), mk(1,2040,2040,7,7),
                    mk(1,0,0,2047,2047), mk(1,2047,2047,2047,2047), 3'b011, 3'd0};

        resetN       = 1'b0;
        frame_start  = 1'b0;
        player_state = '0;
        ai_states    = '0;
        repeat (3) tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(scan_done), 32'd0);
        chk("reset coll", 32'(collision), 32'd0);
        chk("reset idx",  32'(collision_idx), 32'd0);
        chk("reset mask", 32'(collision_mask), 32'd0);
        resetN = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i], 1'b0, vecs[i]);
            tick();
        end

        // Inputs change after the snapshot; result must follow the snapshot.
        run_frame(vecs[0], 1'b1, vecs[8]);
        tick();

        // Restart two cycles in: one scan_done only, for the second snapshot.
        apply(vecs[8]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        apply(vecs[3]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                if (scan_done) pulses++;
                chk("abort mask held", 32'(collision_mask), 32'(vecs[0].mask));
            end
        end
        chk("abort no early done", 32'(pulses), 32'd0);
        check_result("restart", vecs[3], 1'b0);
        tick();

        // frame_start landing on REPORT: report fires and the next scan starts.
        apply(vecs[2]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
        apply(vecs[7]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_result("report+start", vecs[2], 1'b1);
        repeat (4) tick();
        check_result("after report", vecs[7], 1'b0);
        tick();

        // Synchronous reset in the middle of a scan.
        apply(vecs[8]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(scan_done), 32'd0);
        chk("midrst coll", 32'(collision), 32'd0);
        chk("midrst idx",  32'(collision_idx), 32'd0);
        chk("midrst mask", 32'(collision_mask), 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (scan_done || busy) pulses++;
        end
        chk("midrst stays idle", 32'(pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
